// File: rtl/dot_sampler_if.sv
// Pixel-stream, capture-control and face-result signals shared by the
// camera pipeline (master) and dot_sampler (slave).
interface dot_sampler_if;
  logic        capture;
  logic        frame_start;
  logic        pixel_valid;
  logic [9:0]  x;
  logic [9:0]  y;
  logic [7:0]  r;
  logic [7:0]  g;
  logic [7:0]  b;
  logic        busy;
  logic        face_valid;
  logic [26:0] face_colors;

  modport master (
    output capture, frame_start, pixel_valid, x, y, r, g, b,
    input  busy, face_valid, face_colors
  );

  modport slave (
    input  capture, frame_start, pixel_valid, x, y, r, g, b,
    output busy, face_valid, face_colors
  );
endinterface

// File: rtl/dot_sampler.sv
// Accumulates R/G/B over nine 9x9 facelet windows for one frame, then
// classifies each facelet into a 3-bit cube colour code.
module dot_sampler #(
  parameter logic [7:0] HI        = 8'd160,
  parameter logic [7:0] LO        = 8'd90,
  parameter logic [7:0] WHITE_MIN = 8'd170
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  dot_sampler_if.slave bus
);
  localparam int N_DOTS = 9;
  localparam int X0     = 400;
  localparam int Y0     = 250;
  localparam int PITCH  = 50;
  localparam int HALF   = 4;

  // Means are compared without division: mean >= T  <=>  sum >= T*81.
  localparam logic [14:0] HI_S = 15'(int'(HI) * 81);
  localparam logic [14:0] LO_S = 15'(int'(LO) * 81);
  localparam logic [14:0] WH_S = 15'(int'(WHITE_MIN) * 81);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_ACCUM, S_CLASS, S_DONE} state_t;

  state_t          r_state;
  logic [14:0]     r_sum_r [N_DOTS];
  logic [14:0]     r_sum_g [N_DOTS];
  logic [14:0]     r_sum_b [N_DOTS];
  logic [6:0]      r_cnt   [N_DOTS];
  logic [3:0]      r_k;
  logic [8:0][2:0] r_face;
  logic            r_busy;
  logic            r_valid;

  logic [1:0]  w_col, w_row;
  logic        w_col_hit, w_row_hit, w_hit;
  logic [3:0]  w_idx;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    w_col     = 2'd0;
    w_row     = 2'd0;
    w_col_hit = 1'b0;
    w_row_hit = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (int'(bus.x) >= X0 + c*PITCH - HALF && int'(bus.x) <= X0 + c*PITCH + HALF) begin
        w_col     = 2'(c);
        w_col_hit = 1'b1;
      end
      if (int'(bus.y) >= Y0 + c*PITCH - HALF && int'(bus.y) <= Y0 + c*PITCH + HALF) begin
        w_row     = 2'(c);
        w_row_hit = 1'b1;
      end
    end
    w_hit = w_col_hit & w_row_hit;
    w_idx = 4'(w_row) * 4'd3 + 4'(w_col);
  end

  logic [14:0] w_sr, w_sg, w_sb;
  logic [6:0]  w_cnt;
  logic        w_r_hi, w_g_hi, w_b_hi, w_r_lo, w_g_lo, w_b_lo, w_white;
  logic [2:0]  w_code;

  always_comb begin
    w_sr    = r_sum_r[r_k];
    w_sg    = r_sum_g[r_k];
    w_sb    = r_sum_b[r_k];
    w_cnt   = r_cnt[r_k];
    w_r_hi  = (w_sr >= HI_S);
    w_g_hi  = (w_sg >= HI_S);
    w_b_hi  = (w_sb >= HI_S);
    w_r_lo  = (w_sr < LO_S);
    w_g_lo  = (w_sg < LO_S);
    w_b_lo  = (w_sb < LO_S);
    w_white = (w_sr >= WH_S) && (w_sg >= WH_S) && (w_sb >= WH_S);
    w_code  = 3'd0;
    if (w_cnt != 7'd81)                            w_code = 3'd0;
    else if (w_white)                              w_code = 3'd1;
    else if (w_r_hi && w_g_hi && w_b_lo)           w_code = 3'd2;
    else if (w_r_hi && w_g_lo && w_b_lo)           w_code = 3'd3;
    else if (w_r_hi && !w_g_lo && !w_g_hi && w_b_lo) w_code = 3'd4;
    else if (w_g_hi && w_r_lo)                     w_code = 3'd5;
    else if (w_b_hi && w_r_lo && !w_g_hi)          w_code = 3'd6;
  end

  // NOTE: non-blocking assignments only, so every register updates from pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_face  <= '0;
      r_k     <= '0;
      // NOTE: the accumulators are small register arrays, not RAM, so they can take the async reset.
      for (int i = 0; i < N_DOTS; i++) begin
        r_sum_r[i] <= '0;
        r_sum_g[i] <= '0;
        r_sum_b[i] <= '0;
        r_cnt[i]   <= '0;
      end
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.capture) begin
            for (int i = 0; i < N_DOTS; i++) begin
              r_sum_r[i] <= '0;
              r_sum_g[i] <= '0;
              r_sum_b[i] <= '0;
              r_cnt[i]   <= '0;
            end
            r_busy  <= 1'b1;
            r_state <= S_ARM;
          end
        end
        S_ARM: begin
          if (bus.frame_start) r_state <= S_ACCUM;
        end
        S_ACCUM: begin
          // The closing frame_start wins over a coincident pixel.
          if (bus.frame_start) begin
            r_k     <= '0;
            r_state <= S_CLASS;
          end else if (bus.pixel_valid && w_hit) begin
            r_sum_r[w_idx] <= r_sum_r[w_idx] + 15'(bus.r);
            r_sum_g[w_idx] <= r_sum_g[w_idx] + 15'(bus.g);
            r_sum_b[w_idx] <= r_sum_b[w_idx] + 15'(bus.b);
            if (r_cnt[w_idx] != 7'd127) r_cnt[w_idx] <= r_cnt[w_idx] + 7'd1;
          end
        end
        S_CLASS: begin
          r_face[r_k] <= w_code;
          if (r_k == 4'd8) begin
            r_valid <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_k <= r_k + 4'd1;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.face_valid  = r_valid;
  assign bus.face_colors = r_face;
endmodule

// File: tb/tb_dot_sampler.sv
// Randomised and directed frames for dot_sampler; a monitor pops expected
// faces from a scoreboard queue on every face_valid strobe.
module tb_dot_sampler;
  localparam logic [7:0] HI   = 8'd160;
  localparam logic [7:0] LO   = 8'd90;
  localparam logic [7:0] WMIN = 8'd170;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dot_sampler_if bus();

  dot_sampler #(.HI(HI), .LO(LO), .WHITE_MIN(WMIN)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int pulses   = 0;
  int accepted = 0;
  logic [26:0] exp_q [$];
  logic [26:0] mon_exp;

  int m_sr [9];
  int m_sg [9];
  int m_sb [9];
  int m_cnt[9];
  logic [7:0] dr [9];
  logic [7:0] dg [9];
  logic [7:0] db [9];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int cx(int i); return 400 + 50 * (i % 3); endfunction
  function automatic int cy(int i); return 250 + 50 * (i / 3); endfunction

  // Reference model: per-dot sums of every accepted pixel, classified by mean.
  task automatic model_clear();
    for (int i = 0; i < 9; i++) begin
      m_sr[i] = 0; m_sg[i] = 0; m_sb[i] = 0; m_cnt[i] = 0;
    end
  endtask

  task automatic model_pixel(int x, int y, int r, int g, int b);
    for (int i = 0; i < 9; i++) begin
      if (x > cx(i) - 5 && x < cx(i) + 5 && y > cy(i) - 5 && y < cy(i) + 5) begin
        m_sr[i] += r; m_sg[i] += g; m_sb[i] += b;
        if (m_cnt[i] < 127) m_cnt[i]++;
      end
    end
  endtask

  function automatic logic [2:0] classify(int i);
    int  t_hi, t_lo, t_w;
    bit  rh, gh, bh, rl, gl, bl;
    t_hi = int'(HI) * 81;
    t_lo = int'(LO) * 81;
    t_w  = int'(WMIN) * 81;
    rh = m_sr[i] >= t_hi; gh = m_sg[i] >= t_hi; bh = m_sb[i] >= t_hi;
    rl = m_sr[i] <  t_lo; gl = m_sg[i] <  t_lo; bl = m_sb[i] <  t_lo;
    if (m_cnt[i] != 81) return 3'd0;
    if (m_sr[i] >= t_w && m_sg[i] >= t_w && m_sb[i] >= t_w) return 3'd1;
    if (rh && gh && bl) return 3'd2;
    if (rh && gl && bl) return 3'd3;
    if (rh && !gl && !gh && bl) return 3'd4;
    if (gh && rl) return 3'd5;
    if (bh && rl && !gh) return 3'd6;
    return 3'd0;
  endfunction

  function automatic logic [26:0] model_face();
    logic [26:0] f;
    f = '0;
    for (int i = 0; i < 9; i++) f[3*i +: 3] = classify(i);
    return f;
  endfunction

  // Monitor: every face_valid strobe consumes one expected face.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && bus.face_valid) begin
        pulses++;
        if (exp_q.size() == 0) begin
          check("unexpected_face_valid", 32'(bus.face_valid), 32'd0);
        end else begin
          mon_exp = exp_q.pop_front();
          check("face_colors", 32'(bus.face_colors), 32'(mon_exp));
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle(int n);
    bus.pixel_valid = 1'b0;
    bus.capture     = 1'b0;
    bus.frame_start = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic pix(int x, int y, int r, int g, int b, bit valid);
    bus.x = 10'(x); bus.y = 10'(y);
    bus.r = 8'(r);  bus.g = 8'(g);  bus.b = 8'(b);
    bus.pixel_valid = valid;
    if (valid) model_pixel(x, y, r, g, b);
    @(negedge clk);
    bus.pixel_valid = 1'b0;
  endtask

  task automatic capture_req(string name);
    check({name, "_busy_idle"}, 32'(bus.busy), 32'd0);
    bus.capture = 1'b1;
    @(negedge clk);
    bus.capture = 1'b0;
    check({name, "_busy_rise"}, 32'(bus.busy), 32'd1);
  endtask

  task automatic open_frame();
    bus.frame_start = 1'b1;
    @(negedge clk);
    bus.frame_start = 1'b0;
  endtask

  // face_valid must appear after the 9th rising edge following the edge that
  // sampled the closing frame_start, i.e. during the 10th cycle.
  task automatic close_frame(string name, logic [26:0] exp, bit inject_fs, bit extra_pix);
    int seen;
    exp_q.push_back(exp);
    accepted++;
    bus.frame_start = 1'b1;
    if (extra_pix) begin
      bus.x = 10'd400; bus.y = 10'd250;
      bus.r = 8'd0; bus.g = 8'd0; bus.b = 8'd0;
      bus.pixel_valid = 1'b1;
    end
    @(negedge clk);
    bus.frame_start = 1'b0;
    bus.pixel_valid = 1'b0;
    seen = 0;
    for (int n = 1; n <= 30 && seen == 0; n++) begin
      bus.frame_start = inject_fs && (n == 3);
      @(negedge clk);
      if (n == 5) check({name, "_busy_in_class"}, 32'(bus.busy), 32'd1);
      if (bus.face_valid) seen = n;
    end
    bus.frame_start = 1'b0;
    check({name, "_latency"}, 32'(seen), 32'd9);
    @(negedge clk);
    check({name, "_valid_drop"}, 32'(bus.face_valid), 32'd0);
    check({name, "_busy_drop"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic paint_dot(int i, int noise, int omit_idx, int drop_per_mille);
    int rr, gg, bb, k;
    bit v;
    for (int dy = -4; dy <= 4; dy++) begin
      for (int dx = -4; dx <= 4; dx++) begin
        k  = (dy + 4) * 9 + (dx + 4);
        rr = int'(dr[i]) + int'($urandom_range(0, 2 * noise)) - noise;
        gg = int'(dg[i]) + int'($urandom_range(0, 2 * noise)) - noise;
        bb = int'(db[i]) + int'($urandom_range(0, 2 * noise)) - noise;
        rr = rr < 0 ? 0 : (rr > 255 ? 255 : rr);
        gg = gg < 0 ? 0 : (gg > 255 ? 255 : gg);
        bb = bb < 0 ? 0 : (bb > 255 ? 255 : bb);
        v  = (k != omit_idx) && (int'($urandom_range(0, 999)) >= drop_per_mille);
        pix(cx(i) + dx, cy(i) + dy, rr, gg, bb, v);
      end
    end
  endtask

  task automatic paint_all(int noise, int omit_dot, int omit_idx, int drop, int junk);
    for (int i = 0; i < 9; i++) begin
      paint_dot(i, noise, (i == omit_dot) ? omit_idx : -1, drop);
      repeat (junk)
        pix(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
            int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 255)), 1'b1);
    end
  endtask

  task automatic set_dot(int i, int r, int g, int b);
    dr[i] = 8'(r); dg[i] = 8'(g); db[i] = 8'(b);
  endtask

  task automatic set_red_green(int r0);
    for (int i = 0; i < 9; i++) set_dot(i, 30, 200, 40);
    set_dot(0, r0, 20, 20);
  endtask

  task automatic random_colour(int i);
    case ($urandom_range(0, 7))
      0: set_dot(i, $urandom_range(175, 255), $urandom_range(175, 255), $urandom_range(175, 255));
      1: set_dot(i, $urandom_range(165, 255), $urandom_range(165, 255), $urandom_range(0, 85));
      2: set_dot(i, $urandom_range(165, 255), $urandom_range(0, 85), $urandom_range(0, 85));
      3: set_dot(i, $urandom_range(165, 255), $urandom_range(95, 155), $urandom_range(0, 85));
      4: set_dot(i, $urandom_range(0, 85), $urandom_range(165, 255), $urandom_range(0, 255));
      5: set_dot(i, $urandom_range(0, 85), $urandom_range(0, 155), $urandom_range(165, 255));
      6: set_dot(i, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
      default: set_dot(i, $urandom_range(158, 162), $urandom_range(0, 30), $urandom_range(0, 30));
    endcase
  endtask

  initial begin
    bus.capture = 1'b0; bus.frame_start = 1'b0; bus.pixel_valid = 1'b0;
    bus.x = '0; bus.y = '0; bus.r = '0; bus.g = '0; bus.b = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_valid", 32'(bus.face_valid), 32'd0);
    check("reset_face", 32'(bus.face_colors), 32'd0);
    rst_n = 1'b1;
    idle(2);

    for (int i = 0; i < 9; i++) set_dot(i, 255, 255, 255);
    capture_req("white");
    idle(2); open_frame();
    paint_all(0, -1, -1, 0, 0);
    close_frame("white", 27'o111111111, 1'b0, 1'b0);

    for (int i = 0; i < 9; i++) set_dot(i, 30, 200, 40);
    set_dot(0, 200, 40, 40); set_dot(4, 20, 40, 200); set_dot(8, 220, 220, 30);
    capture_req("mixed");
    open_frame();
    paint_all(0, -1, -1, 0, 1);
    close_frame("mixed", 27'o255565553, 1'b0, 1'b0);

    capture_req("rst");
    open_frame();
    paint_dot(0, 0, -1, 0);
    rst_n = 1'b0;
    #1;
    check("midaccum_rst_busy", 32'(bus.busy), 32'd0);
    check("midaccum_rst_valid", 32'(bus.face_valid), 32'd0);
    check("midaccum_rst_face", 32'(bus.face_colors), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    open_frame();
    check("idle_frame_start_ignored", 32'(bus.busy), 32'd0);

    set_red_green(200);
    capture_req("edges");
    open_frame();
    for (int t = -5; t <= 5; t++) begin
      pix(395, 250 + t, 0, 0, 0, 1'b1);
      pix(405, 250 + t, 0, 0, 0, 1'b1);
      pix(400 + t, 245, 0, 0, 0, 1'b1);
      pix(400 + t, 255, 0, 0, 0, 1'b1);
    end
    paint_all(0, -1, -1, 0, 0);
    close_frame("edges", 27'o555555553, 1'b0, 1'b0);

    capture_req("omit");
    open_frame();
    paint_all(0, 0, 40, 0, 0);
    close_frame("omit", 27'o555555550, 1'b0, 1'b0);

    set_red_green(160);
    capture_req("thr160");
    open_frame();
    paint_all(0, -1, -1, 0, 0);
    close_frame("thr160", 27'o555555553, 1'b0, 1'b0);

    set_red_green(159);
    capture_req("thr159");
    open_frame();
    paint_all(0, -1, -1, 0, 0);
    close_frame("thr159", 27'o555555550, 1'b0, 1'b0);

    // Second capture mid-ACCUM, black pixel with the closing frame_start,
    // frame_start during CLASS: none of these may disturb the result.
    set_red_green(200);
    capture_req("proto");
    open_frame();
    paint_dot(0, 0, -1, 0);
    bus.capture = 1'b1;
    pix(10, 10, 0, 0, 0, 1'b1);
    bus.capture = 1'b0;
    check("proto_busy_held", 32'(bus.busy), 32'd1);
    for (int i = 1; i < 9; i++) paint_dot(i, 0, -1, 0);
    close_frame("proto", 27'o555555553, 1'b1, 1'b1);

    for (int f = 0; f < 8; f++) begin
      model_clear();
      for (int i = 0; i < 9; i++) random_colour(i);
      capture_req("rand");
      idle($urandom_range(0, 3));
      open_frame();
      paint_all($urandom_range(0, 12), -1, -1, (f % 3 == 2) ? 3 : 0, $urandom_range(0, 2));
      close_frame("rand", model_face(), 1'b0, 1'b0);
    end

    idle(5);
    check("pulse_count", 32'(pulses), 32'(accepted));
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/dot_sampler.md
# dot_sampler

Samples the camera pixel stream at the nine fixed cube-facelet dot windows that the VGA overlay marks on screen. It accumulates R/G/B over each window for one full frame, classifies each facelet into a cube colour code, and presents a 27-bit face result with a one-cycle valid strobe. It sits between the camera/pixel pipeline and the cube-state capture logic.

## Interface
- HI, default 8'd160: mean channel level counted as "high".
- LO, default 8'd90: mean channel level counted as "low".
- WHITE_MIN, default 8'd170: minimum mean on all three channels for white.
- Clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- capture  in  1  one-cycle request to sample the next full frame.
- frame_start  in  1  one-cycle pulse marking the start of a frame, issued before that frame's first pixel.
- pixel_valid  in  1  qualifies x, y, r, g, b.
- x, y  in  10 each  pixel coordinates.
- r, g, b  in  8 each  pixel colour.
- busy  out  1  high from capture acceptance until face_valid.
- face_valid  out  1  one-cycle strobe when face_colors has updated.
- face_colors  out  27  nine 3-bit codes. Dot i occupies bits [3i+2:3i].

## Operation
- Dot centres, index i, row-major:
  - 0 (400,250), 1 (450,250), 2 (500,250)
  - 3 (400,300), 4 (450,300), 5 (500,300)
  - 6 (400,350), 7 (450,350), 8 (500,350)
- Window for centre (cx,cy): cx-5 < x < cx+5 and cy-5 < y < cy+5, bounds exclusive. This gives 9×9 = 81 pixels per dot.
- Per dot: three 15-bit channel sums (max 81×255 = 20655) and a 7-bit pixel counter that saturates at 127.
- FSM states:
  - IDLE: capture=1 → ARM. Sums and counters are cleared on entry to ARM.
  - ARM: frame_start=1 → ACCUM.
  - ACCUM: a pixel with pixel_valid=1 that falls inside window i adds into dot i. Next frame_start → CLASS.
  - CLASS: 9 cycles, dot index k from 0 to 8. Dot k is classified and written into face_colors[3k+2:3k].
  - DONE: 1 cycle with face_valid=1 → IDLE.
- Classification compares each sum S against threshold×81; "mean ≥ T" means S ≥ T×81. The first matching rule wins:
  - count ≠ 81 → 0 (unknown)
  - R,G,B all ≥ WHITE_MIN → 1 (white)
  - R≥HI, G≥HI, B<LO → 2 (yellow)
  - R≥HI, G<LO, B<LO → 3 (red)
  - R≥HI, LO≤G<HI, B<LO → 4 (orange)
  - G≥HI, R<LO → 5 (green)
  - B≥HI, R<LO, G<HI → 6 (blue)
  - otherwise → 0
  - Code 7 is never produced.
- face_colors holds its value until the next CLASS overwrites it.

## Timing
- Reset values: busy=0, face_valid=0, face_colors=0, state IDLE, all sums and counters 0.
- busy rises the cycle after capture is sampled in IDLE. It falls the cycle after DONE, together with face_valid dropping.
- capture is ignored outside IDLE.
- frame_start is ignored in IDLE, CLASS and DONE.
- A pixel_valid asserted in the same cycle as frame_start is not accumulated.
- Latency: the frame_start that ends ACCUM is followed by CLASS for 9 cycles. face_valid is high on the 10th cycle after that frame_start edge.
- The field for dot k is visible in face_colors the cycle after its CLASS step. Intermediate values are visible during CLASS.
- Pixels outside all windows are dropped. Windows do not overlap.
- A reset assertion at any point, including mid-ACCUM or mid-CLASS, immediately returns all outputs and state to their reset values.

## Test plan
- Reset: assert reset mid-ACCUM → busy=0, face_valid=0, face_colors=0. A new capture afterwards completes normally.
- Uniform white frame (255,255,255) → every field is 3'd1, and face_valid is high exactly 10 cycles after the closing frame_start.
- Mixed frame: dot0 (200,40,40), dot4 (20,40,200), dot8 (220,220,30), all other dots (30,200,40) → codes 3, 6 and 2 respectively, with 5 elsewhere.
- Window edges: dot0 is red, and pixels at x=395, x=405, y=245 and y=255 are black → still code 3. Omitting pixel_valid for one interior pixel of dot0 → code 0 (count 80).
- Threshold edge: dot0 mean (160,20,20) → 3. Mean (159,20,20) → 0.
- Protocol:
  - A second capture during ACCUM is ignored.
  - A frame_start during CLASS is ignored.
  - Exactly one face_valid pulse is produced per accepted capture.
  - frame_start with simultaneous pixel_valid: that pixel is not counted.
